branch_comp_seq: RTL and testbench

Parametrised, multi-cycle successor to the single-cycle branch comparator. It compares rs1/rs2 one slice per clock, starting at the MSB slice, and can exit as soon as a slice decides the result. Signedness is handled correctly, with the sign bit inverted on the top slice. It decodes funct3 into a registered branch-taken decision. It sits between register-file read and PC-select logic, with a valid/ready handshake on both sides, so it can trade latency for comparator width in area-constrained builds.

---
 rtl/branch_comp_seq.sv | 152 +++++++++++++++
 tb/tb_branch_comp_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/branch_comp_seq.sv
// Sliced branch comparator: MSB-first, one slice per clock, optional early exit; result in 1..NSLICE cycles.
// Valid/ready on both sides; one request in flight, results held in DONE until out_ready_i.
module branch_comp_seq #(
   parameter int REG_WIDTH   = 32,
   parameter int SLICE_WIDTH = 8,
   parameter bit EARLY_EXIT  = 1'b1
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 flush_i,
   input  logic                 pc_write_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic                 br_un_i,
   input  logic [2:0]           funct3_i,
   input  logic [REG_WIDTH-1:0] data_rs1_i,
   input  logic [REG_WIDTH-1:0] data_rs2_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic                 br_eq_o,
   output logic                 br_lt_o,
   output logic                 br_taken_o,
   output logic                 br_illegal_o,
   output logic                 busy_o
);
   localparam int NSLICE = REG_WIDTH / SLICE_WIDTH;
   localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CMP  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   typedef struct packed {
      logic [REG_WIDTH-1:0] rs1;
      logic [REG_WIDTH-1:0] rs2;
      logic                 un;
      logic [2:0]           f3;
   } req_t;

   logic [1:0]             state_q, state_d;
   req_t                   req_q, req_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic                   eq_q, eq_d, lt_q, lt_d;
   logic                   taken_q, taken_d, ill_q, ill_d;
   logic                   dec_q, dec_d;
   logic [SLICE_WIDTH-1:0] s1, s2, sgn_mask;
   logic                   accept, diff, res_dec, res_lt, last;

   function automatic logic taken_fn(input logic [2:0] f3, input logic eq, input logic lt);
      case (f3)
         3'b000:          return eq;
         3'b001:          return !eq;
         3'b100, 3'b110:  return lt;
         3'b101, 3'b111:  return !lt;
         default:         return 1'b0;
      endcase
   endfunction

   assign in_ready_o   = (state_q == S_IDLE) && rst_n_i && !flush_i;
   assign accept       = in_valid_i && in_ready_o;
   assign out_valid_o  = (state_q == S_DONE);
   assign busy_o       = (state_q != S_IDLE);
   assign br_eq_o      = eq_q;
   assign br_lt_o      = lt_q;
   assign br_taken_o   = taken_q;
   assign br_illegal_o = ill_q;

   always_comb begin
      // Flipping the sign bit of the top slice turns signed order into unsigned order.
      sgn_mask = '0;
      sgn_mask[SLICE_WIDTH-1] = (idx_q == IW'(NSLICE-1)) && !req_q.un;
      s1 = req_q.rs1[int'(idx_q)*SLICE_WIDTH +: SLICE_WIDTH] ^ sgn_mask;
      s2 = req_q.rs2[int'(idx_q)*SLICE_WIDTH +: SLICE_WIDTH] ^ sgn_mask;
      diff    = (s1 != s2);
      res_dec = dec_q || diff;
      // Once a higher slice has decided, lower slices must not overwrite lt.
      res_lt  = dec_q ? lt_q : (diff && (s1 < s2));
      last    = (idx_q == '0) || (EARLY_EXIT && diff);

      state_d = state_q;
      req_d   = req_q;
      idx_d   = idx_q;
      eq_d    = eq_q;
      lt_d    = lt_q;
      taken_d = taken_q;
      ill_d   = ill_q;
      dec_d   = dec_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               req_d.rs1 = data_rs1_i;
               req_d.rs2 = data_rs2_i;
               req_d.un  = br_un_i;
               req_d.f3  = funct3_i;
               idx_d     = IW'(NSLICE-1);
               ill_d     = (funct3_i[2:1] == 2'b01);
               eq_d      = 1'b0;
               lt_d      = 1'b0;
               taken_d   = 1'b0;
               dec_d     = 1'b0;
               state_d   = pc_write_i ? S_CMP : S_DONE;
            end
         end
         S_CMP: begin
            if (last) begin
               eq_d    = !res_dec;
               lt_d    = res_lt;
               taken_d = taken_fn(req_q.f3, !res_dec, res_lt);
               state_d = S_DONE;
            end else begin
               idx_d = idx_q - IW'(1);
               dec_d = res_dec;
               lt_d  = res_lt;
            end
         end
         S_DONE: begin
            if (out_ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         req_q   <= '0;
         idx_q   <= '0;
         eq_q    <= 1'b0;
         lt_q    <= 1'b0;
         taken_q <= 1'b0;
         ill_q   <= 1'b0;
         dec_q   <= 1'b0;
      end else if (flush_i) begin
         state_q <= S_IDLE;
         eq_q    <= 1'b0;
         lt_q    <= 1'b0;
         taken_q <= 1'b0;
         ill_q   <= 1'b0;
         dec_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         idx_q   <= idx_d;
         eq_q    <= eq_d;
         lt_q    <= lt_d;
         taken_q <= taken_d;
         ill_q   <= ill_d;
         dec_q   <= dec_d;
      end
   end
endmodule

// File: tb/tb_branch_comp_seq.sv
// Directed bench: instance 0 uses early exit, instance 1 fixed latency; expected values hand-computed.
module tb_branch_comp_seq;
   logic        clk, rst_n, flush, pc_write, br_un, out_ready;
   logic [2:0]  funct3;
   logic [31:0] rs1, rs2;
   logic        in_valid [2];
   logic        in_ready [2];
   logic        ov [2];
   logic        eq [2];
   logic        lt [2];
   logic        tk [2];
   logic        il [2];
   logic        busy [2];
   int          tests = 0, failed = 0;
   int          k;
   logic        seen;

   branch_comp_seq #(.REG_WIDTH(32), .SLICE_WIDTH(8), .EARLY_EXIT(1'b1)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .pc_write_i(pc_write),
      .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .br_un_i(br_un),
      .funct3_i(funct3), .data_rs1_i(rs1), .data_rs2_i(rs2),
      .out_valid_o(ov[0]), .out_ready_i(out_ready), .br_eq_o(eq[0]), .br_lt_o(lt[0]),
      .br_taken_o(tk[0]), .br_illegal_o(il[0]), .busy_o(busy[0]));

   branch_comp_seq #(.REG_WIDTH(32), .SLICE_WIDTH(8), .EARLY_EXIT(1'b0)) dut_fix (
      .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .pc_write_i(pc_write),
      .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .br_un_i(br_un),
      .funct3_i(funct3), .data_rs1_i(rs1), .data_rs2_i(rs2),
      .out_valid_o(ov[1]), .out_ready_i(out_ready), .br_eq_o(eq[1]), .br_lt_o(lt[1]),
      .br_taken_o(tk[1]), .br_illegal_o(il[1]), .busy_o(busy[1]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issue one request on instance sel, wait for out_valid, check latency and results.
   task automatic run(input int sel, input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic un, input logic [2:0] f3, input logic pw, input int exp_k,
                      input logic e_eq, input logic e_lt, input logic e_tk, input logic e_il);
      rs1 = a; rs2 = b; br_un = un; funct3 = f3; pc_write = pw;
      in_valid[sel] = 1'b1;
      @(posedge clk); #1;
      in_valid[sel] = 1'b0;
      k = 0;
      while (k < 20) begin
         @(posedge clk); #1;
         k++;
         if (ov[sel]) break;
      end
      chk({tag, "_k"}, k, exp_k);
      chk({tag, "_eq"}, eq[sel], e_eq);
      chk({tag, "_lt"}, lt[sel], e_lt);
      chk({tag, "_taken"}, tk[sel], e_tk);
      chk({tag, "_illegal"}, il[sel], e_il);
   endtask

   task automatic release_out(input int sel, input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_rel_valid"}, ov[sel], 1'b0);
      chk({tag, "_rel_busy"}, busy[sel], 1'b0);
      chk({tag, "_rel_ready"}, in_ready[sel], 1'b1);
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; pc_write = 1'b1; br_un = 1'b0; out_ready = 1'b0;
      funct3 = 3'b000; rs1 = '0; rs2 = '0;
      in_valid[0] = 1'b0; in_valid[1] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_outs", {ov[0], eq[0], lt[0], tk[0], il[0], busy[0]}, 6'b0);
      chk("rst_in_ready", in_ready[0], 1'b0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", in_ready[0], 1'b1);

      run(0, "sgn_lt", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b100, 1'b1, 1, 1'b0, 1'b1, 1'b1, 1'b0);
      release_out(0, "sgn_lt");
      run(0, "uns_ltu", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'b110, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
      release_out(0, "uns_ltu");
      run(0, "uns_geu", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'b111, 1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b0);
      release_out(0, "uns_geu");
      run(0, "eq_full", 32'h1234_5678, 32'h1234_5678, 1'b0, 3'b000, 1'b1, 4, 1'b1, 1'b0, 1'b1, 1'b0);
      release_out(0, "eq_full");

      run(1, "fix_sgn", 32'h8000_0000, 32'h0000_0000, 1'b0, 3'b100, 1'b1, 4, 1'b0, 1'b1, 1'b1, 1'b0);
      release_out(1, "fix_sgn");
      run(1, "fix_first", 32'h8000_0001, 32'h0000_0000, 1'b0, 3'b101, 1'b1, 4, 1'b0, 1'b1, 1'b0, 1'b0);
      release_out(1, "fix_first");
      run(1, "fix_eq", 32'hA5A5_0F0F, 32'hA5A5_0F0F, 1'b1, 3'b001, 1'b1, 4, 1'b1, 1'b0, 1'b0, 1'b0);
      release_out(1, "fix_eq");

      run(0, "low_slice", 32'h0000_0100, 32'h0000_0101, 1'b0, 3'b001, 1'b1, 4, 1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("hold_valid", ov[0], 1'b1);
         chk("hold_res", {eq[0], lt[0], tk[0], il[0]}, 4'b0110);
         chk("hold_in_ready", in_ready[0], 1'b0);
      end
      release_out(0, "low_slice");

      run(0, "nopc", 32'd5, 32'd5, 1'b0, 3'b000, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
      release_out(0, "nopc");
      run(0, "nopc_ill", 32'd5, 32'd5, 1'b0, 3'b010, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1);
      release_out(0, "nopc_ill");

      rs1 = '0; rs2 = '0; br_un = 1'b0; funct3 = 3'b011; pc_write = 1'b1;
      in_valid[0] = 1'b1;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      @(posedge clk); #1;
      flush = 1'b1;
      #1;
      chk("flush_in_ready_low", in_ready[0], 1'b0);
      @(posedge clk); #1;
      flush = 1'b0;
      #1;
      chk("flush_outs", {ov[0], eq[0], lt[0], tk[0], il[0], busy[0]}, 6'b0);
      chk("flush_in_ready", in_ready[0], 1'b1);
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         seen = seen | ov[0];
      end
      chk("flush_no_valid", seen, 1'b0);

      funct3 = 3'b010;
      in_valid[0] = 1'b1;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_in_ready", in_ready[0], 1'b0);
      @(posedge clk); #1;
      chk("rst_mid_outs", {ov[0], eq[0], lt[0], tk[0], il[0], busy[0]}, 6'b0);
      chk("rst_mid_in_ready2", in_ready[0], 1'b0);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         seen = seen | ov[0];
      end
      chk("rst_mid_no_valid", seen, 1'b0);
      chk("rst_mid_ready_after", in_ready[0], 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
